// File: rtl/div_unit_pkg.sv
// Shared sizing for the iterative divider and its datapath step.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor magnitude.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // The shifted partial remainder needs one extra bit: an unsigned divisor may be close to 2^WIDTH.
    assign rem_sh = {rem_i, quo_i[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvsr_i};

    assign rem_o  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_o  = {quo_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU unit: 1 quotient bit per cycle, with sign pre- and post-processing.
// Quotient drives LO, remainder drives HI; both are held until the next completion.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             div_busy,
    output logic             div_done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] dvnd_raw_q, dvnd_raw_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] step_rem, step_quo;

    assign a_neg = div_signed & dividend[WIDTH-1];
    assign b_neg = div_signed & divisor[WIDTH-1];

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvsr_d     = dvsr_q;
        dvnd_raw_d = dvnd_raw_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        q_d        = q_q;
        r_d        = r_q;

        unique case (state_q)
            IDLE: begin
                if (div_start) begin
                    dvnd_raw_d = dividend;
                    sa_d       = a_neg;
                    sb_d       = b_neg;
                    quo_d      = a_neg ? -dividend : dividend;
                    dvsr_d     = b_neg ? -divisor : divisor;
                    rem_d      = '0;
                    cnt_d      = CNT_W'(WIDTH - 1);
                    busy_d     = 1'b1;
                    state_d    = CALC;
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == '0) begin
                    state_d = SIGN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SIGN: begin
                // A zero divisor has a zero magnitude; its result is fixed rather than computed.
                if (dvsr_q == '0) begin
                    q_d = '1;
                    r_d = dvnd_raw_q;
                end else begin
                    q_d = (sa_q ^ sb_q) ? -quo_q : quo_q;
                    r_d = sa_q ? -rem_q : rem_q;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            dvnd_raw_q <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvsr_q     <= dvsr_d;
            dvnd_raw_q <= dvnd_raw_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            q_q        <= q_d;
            r_q        <= r_d;
        end
    end

    assign div_busy = busy_q;
    assign div_done = done_q;
    assign q        = q_q;
    assign r        = r_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed checks of div_unit: latency, signed/unsigned results, divide by zero, start handling, reset abort.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        div_start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_busy;
    logic        div_done;
    logic [31:0] q;
    logic [31:0] r;

    int total = 0;
    int bad   = 0;
    int n;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .div_start  (div_start),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .q          (q),
        .r          (r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the request is taken on the next rising edge, then operands are scrambled.
    task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        div_start  = 1'b1;
        @(posedge clk);
        #1;
        div_start  = 1'b0;
        dividend   = 32'hDEADBEEF;
        divisor    = 32'h0;
        div_signed = ~sgn;
    endtask

    // Counts falling edges with div_busy high; returns at the first falling edge with div_busy low.
    task automatic wait_done(output int cycles);
        cycles = 0;
        @(negedge clk);
        while (div_busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er);
        int cyc;
        start_op(sgn, a, b);
        wait_done(cyc);
        check({tag, "_busy_cycles"}, cyc, 32'd33);
        check({tag, "_done"}, div_done, 32'd1);
        check({tag, "_q"}, q, eq);
        check({tag, "_r"}, r, er);
        @(negedge clk);
        check({tag, "_done_pulse"}, div_done, 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        dividend   = '0;
        divisor    = '0;
        #12;
        check("rst_busy", div_busy, 32'd0);
        check("rst_done", div_done, 32'd0);
        check("rst_q", q, 32'd0);
        check("rst_r", r, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_op("divu_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2);
        run_op("div_m7_2",     1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF);
        run_op("div_7_m2",     1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1);
        run_op("div_min_m1",   1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0);
        run_op("divu_max_1",   1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0);
        run_op("divu_max_16",  1'b0, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF,   32'hF);
        run_op("divu_by0",     1'b0, 32'h1234,       32'd0,          32'hFFFFFFFF,   32'h1234);
        run_op("div_by0",      1'b1, 32'hFFFFFF00,   32'd0,          32'hFFFFFFFF,   32'hFFFFFF00);

        // Second start while busy must be ignored; results stay put while busy.
        start_op(1'b0, 32'd1000, 32'd10);
        for (int i = 0; i < 10; i++) @(negedge clk);
        check("hold_q_busy", q, 32'hFFFFFFFF);
        check("hold_r_busy", r, 32'hFFFFFF00);
        div_start  = 1'b1;
        div_signed = 1'b1;
        dividend   = 32'd55;
        divisor    = 32'd5;
        @(posedge clk);
        #1;
        div_start  = 1'b0;
        dividend   = 32'd7;
        wait_done(n);
        check("ign_busy_cycles", n + 10, 32'd33);
        check("ign_done", div_done, 32'd1);
        check("ign_q", q, 32'd100);
        check("ign_r", r, 32'd0);

        // Back-to-back: new start in the div_done cycle.
        start_op(1'b0, 32'd4096, 32'd3);
        check("b2b_done_fall", div_done, 32'd0);
        check("b2b_busy_rise", div_busy, 32'd1);
        wait_done(n);
        check("b2b_busy_cycles", n, 32'd33);
        check("b2b_done", div_done, 32'd1);
        check("b2b_q", q, 32'h555);
        check("b2b_r", r, 32'd1);
        @(negedge clk);

        // Asynchronous abort mid-operation.
        start_op(1'b0, 32'd100, 32'd7);
        for (int i = 0; i < 15; i++) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_busy", div_busy, 32'd0);
        check("abort_done", div_done, 32'd0);
        check("abort_q", q, 32'd0);
        check("abort_r", r, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op("post_rst_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
